// File: rtl/axil_ctrl_master.sv
// rtl/axil_ctrl_master.sv - AXI4-Lite initiator driven by a command stream
// Decodes one command packet, runs a single-beat read or write, returns a 2-beat response.
module axil_ctrl_master #(
    parameter int BW       = 32,
    parameter int BW_AXI   = 32,
    parameter int BWB_AXI  = BW_AXI / 8,
    parameter int AXI_ADDR = 8
) (
    input  logic                clk_control,
    input  logic                clk_control_rst_high,

    input  logic                cmd_TVALID,
    output logic                cmd_TREADY,
    input  logic [BW-1:0]       cmd_TDATA,
    input  logic                cmd_TLAST,

    output logic                rsp_TVALID,
    input  logic                rsp_TREADY,
    output logic [BW-1:0]       rsp_TDATA,
    output logic                rsp_TLAST,

    output logic [AXI_ADDR-1:0] m_AXI_AWADDR,
    output logic                m_AXI_AWVALID,
    input  logic                m_AXI_AWREADY,
    output logic [BW_AXI-1:0]   m_AXI_WDATA,
    output logic [BWB_AXI-1:0]  m_AXI_WSTRB,
    output logic                m_AXI_WVALID,
    input  logic                m_AXI_WREADY,
    input  logic [1:0]          m_AXI_BRESP,
    input  logic                m_AXI_BVALID,
    output logic                m_AXI_BREADY,
    output logic [AXI_ADDR-1:0] m_AXI_ARADDR,
    output logic                m_AXI_ARVALID,
    input  logic                m_AXI_ARREADY,
    input  logic [BW_AXI-1:0]   m_AXI_RDATA,
    input  logic [1:0]          m_AXI_RRESP,
    input  logic                m_AXI_RVALID,
    output logic                m_AXI_RREADY
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WDATA,
        S_WR,
        S_WB,
        S_RD,
        S_RR,
        S_RSP0,
        S_RSP1,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_cmd_tready;
    logic                  r_write;
    logic                  r_malformed;
    logic [AXI_ADDR-1:0]   r_addr;
    logic [BWB_AXI-1:0]    r_wstrb;
    logic [BW_AXI-1:0]     r_wdata;
    logic [BW_AXI-1:0]     r_rdata;
    logic [1:0]            r_resp;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic                  w_cmd_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_done_nxt;
    logic                  w_w_done_nxt;
    logic                  w_hdr_write;

    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_bready;
    logic                  w_arvalid;
    logic                  w_rready;
    logic                  w_rsp_tvalid;
    logic                  w_rsp_tlast;
    logic [BW-1:0]         w_rsp_tdata;
    logic [BW-1:0]         w_status;
    logic                  w_unused;

    assign w_cmd_hs      = cmd_TVALID & r_cmd_tready;
    assign w_aw_hs       = w_awvalid & m_AXI_AWREADY;
    assign w_w_hs        = w_wvalid & m_AXI_WREADY;
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done | w_w_hs;
    assign w_hdr_write   = cmd_TDATA[31];

    // Header bits that carry no meaning for this block.
    assign w_unused = ^{cmd_TDATA[30:28], cmd_TDATA[23:AXI_ADDR]};

    assign w_status = {r_write, 27'b0, r_malformed, 1'b0, r_resp};

    // State register
    always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
        if (clk_control_rst_high) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (w_hdr_write) begin
                        w_next = cmd_TLAST ? S_RSP0 : S_WDATA;
                    end else begin
                        w_next = cmd_TLAST ? S_RD : S_DRAIN;
                    end
                end
            end
            S_WDATA: begin
                if (w_cmd_hs) begin
                    w_next = cmd_TLAST ? S_WR : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_cmd_hs && cmd_TLAST) begin
                    w_next = r_write ? S_WR : S_RSP0;
                end
            end
            S_WR: begin
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                if (m_AXI_BVALID) begin
                    w_next = S_RSP0;
                end
            end
            S_RD: begin
                if (m_AXI_ARREADY) begin
                    w_next = S_RR;
                end
            end
            S_RR: begin
                if (m_AXI_RVALID) begin
                    w_next = S_RSP0;
                end
            end
            S_RSP0: begin
                if (rsp_TREADY) begin
                    w_next = S_RSP1;
                end
            end
            S_RSP1: begin
                if (rsp_TREADY) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; all data fields come from registers so they hold while stalled.
    always_comb begin
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_rsp_tvalid = 1'b0;
        w_rsp_tlast  = 1'b0;
        w_rsp_tdata  = '0;
        case (r_state)
            S_WR: begin
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
            end
            S_WB: w_bready  = 1'b1;
            S_RD: w_arvalid = 1'b1;
            S_RR: w_rready  = 1'b1;
            S_RSP0: begin
                w_rsp_tvalid = 1'b1;
                w_rsp_tdata  = BW'(r_rdata);
            end
            S_RSP1: begin
                w_rsp_tvalid = 1'b1;
                w_rsp_tlast  = 1'b1;
                w_rsp_tdata  = w_status;
            end
            default: begin
                w_rsp_tdata = '0;
            end
        endcase
    end

    // Command ready is registered so it stays low through reset and rises on the first clock after release.
    always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
        if (clk_control_rst_high) begin
            r_cmd_tready <= 1'b0;
        end else begin
            r_cmd_tready <= (w_next == S_IDLE) || (w_next == S_WDATA) || (w_next == S_DRAIN);
        end
    end

    // Transaction datapath
    always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
        if (clk_control_rst_high) begin
            r_write     <= 1'b0;
            r_malformed <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_resp      <= 2'b00;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_cmd_hs) begin
                r_write     <= w_hdr_write;
                r_malformed <= w_hdr_write ? cmd_TLAST : ~cmd_TLAST;
                r_addr      <= cmd_TDATA[AXI_ADDR-1:0];
                r_wstrb     <= cmd_TDATA[24 +: BWB_AXI];
                r_wdata     <= '0;
                r_rdata     <= '0;
                r_resp      <= 2'b00;
            end

            if (r_state == S_WDATA && w_cmd_hs) begin
                r_wdata <= cmd_TDATA[BW_AXI-1:0];
                if (!cmd_TLAST) begin
                    r_malformed <= 1'b1;
                end
            end

            if (r_state == S_WR) begin
                r_aw_done <= w_aw_done_nxt;
                r_w_done  <= w_w_done_nxt;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (r_state == S_WB && m_AXI_BVALID) begin
                r_resp <= m_AXI_BRESP;
            end

            if (r_state == S_RR && m_AXI_RVALID) begin
                r_rdata <= m_AXI_RDATA;
                r_resp  <= m_AXI_RRESP;
            end
        end
    end

    assign cmd_TREADY    = r_cmd_tready;
    assign rsp_TVALID    = w_rsp_tvalid;
    assign rsp_TDATA     = w_rsp_tdata;
    assign rsp_TLAST     = w_rsp_tlast;
    assign m_AXI_AWADDR  = r_addr;
    assign m_AXI_AWVALID = w_awvalid;
    assign m_AXI_WDATA   = r_wdata;
    assign m_AXI_WSTRB   = r_wstrb;
    assign m_AXI_WVALID  = w_wvalid;
    assign m_AXI_BREADY  = w_bready;
    assign m_AXI_ARADDR  = r_addr;
    assign m_AXI_ARVALID = w_arvalid;
    assign m_AXI_RREADY  = w_rready;

endmodule

// File: tb/tb_axil_ctrl_master.sv
// tb/tb_axil_ctrl_master.sv - self-checking bench for axil_ctrl_master
module tb_axil_ctrl_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_TVALID = 1'b0;
    logic        cmd_TREADY;
    logic [31:0] cmd_TDATA  = 32'h0;
    logic        cmd_TLAST  = 1'b0;
    logic        rsp_TVALID;
    logic        rsp_TREADY = 1'b0;
    logic [31:0] rsp_TDATA;
    logic        rsp_TLAST;

    logic [7:0]  m_AXI_AWADDR;
    logic        m_AXI_AWVALID, m_AXI_AWREADY;
    logic [31:0] m_AXI_WDATA;
    logic [3:0]  m_AXI_WSTRB;
    logic        m_AXI_WVALID, m_AXI_WREADY;
    logic [1:0]  m_AXI_BRESP;
    logic        m_AXI_BVALID, m_AXI_BREADY;
    logic [7:0]  m_AXI_ARADDR;
    logic        m_AXI_ARVALID, m_AXI_ARREADY;
    logic [31:0] m_AXI_RDATA;
    logic [1:0]  m_AXI_RRESP;
    logic        m_AXI_RVALID, m_AXI_RREADY;

    axil_ctrl_master #(.BW(32), .BW_AXI(32), .BWB_AXI(4), .AXI_ADDR(8)) dut (
        .clk_control          (clk),
        .clk_control_rst_high (rst),
        .cmd_TVALID           (cmd_TVALID),
        .cmd_TREADY           (cmd_TREADY),
        .cmd_TDATA            (cmd_TDATA),
        .cmd_TLAST            (cmd_TLAST),
        .rsp_TVALID           (rsp_TVALID),
        .rsp_TREADY           (rsp_TREADY),
        .rsp_TDATA            (rsp_TDATA),
        .rsp_TLAST            (rsp_TLAST),
        .m_AXI_AWADDR         (m_AXI_AWADDR),
        .m_AXI_AWVALID        (m_AXI_AWVALID),
        .m_AXI_AWREADY        (m_AXI_AWREADY),
        .m_AXI_WDATA          (m_AXI_WDATA),
        .m_AXI_WSTRB          (m_AXI_WSTRB),
        .m_AXI_WVALID         (m_AXI_WVALID),
        .m_AXI_WREADY         (m_AXI_WREADY),
        .m_AXI_BRESP          (m_AXI_BRESP),
        .m_AXI_BVALID         (m_AXI_BVALID),
        .m_AXI_BREADY         (m_AXI_BREADY),
        .m_AXI_ARADDR         (m_AXI_ARADDR),
        .m_AXI_ARVALID        (m_AXI_ARVALID),
        .m_AXI_ARREADY        (m_AXI_ARREADY),
        .m_AXI_RDATA          (m_AXI_RDATA),
        .m_AXI_RRESP          (m_AXI_RRESP),
        .m_AXI_RVALID         (m_AXI_RVALID),
        .m_AXI_RREADY         (m_AXI_RREADY)
    );

    // Slave model: configurable AW/W ready delays, immediate AR, one-cycle-later B/R.
    int          aw_delay  = 0;
    int          w_delay   = 0;
    logic [31:0] rdata_val = 32'h0;
    logic [1:0]  rresp_val = 2'b00;
    logic [1:0]  bresp_val = 2'b00;
    int          aw_wait, w_wait;
    logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;

    assign m_AXI_AWREADY = m_AXI_AWVALID && (aw_wait >= aw_delay);
    assign m_AXI_WREADY  = m_AXI_WVALID && (w_wait >= w_delay);
    assign m_AXI_ARREADY = m_AXI_ARVALID;
    assign m_AXI_BVALID  = s_bvalid;
    assign m_AXI_BRESP   = bresp_val;
    assign m_AXI_RVALID  = s_rvalid;
    assign m_AXI_RDATA   = rdata_val;
    assign m_AXI_RRESP   = rresp_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait  <= 0;
            w_wait   <= 0;
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
        end else begin
            aw_wait <= (m_AXI_AWVALID && !m_AXI_AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (m_AXI_WVALID && !m_AXI_WREADY) ? w_wait + 1 : 0;
            if (m_AXI_AWVALID && m_AXI_AWREADY) s_aw_got <= 1'b1;
            if (m_AXI_WVALID && m_AXI_WREADY)   s_w_got  <= 1'b1;
            if ((s_aw_got || (m_AXI_AWVALID && m_AXI_AWREADY)) &&
                (s_w_got || (m_AXI_WVALID && m_AXI_WREADY)) && !s_bvalid) begin
                s_bvalid <= 1'b1;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end
            if (s_bvalid && m_AXI_BREADY) s_bvalid <= 1'b0;
            if (m_AXI_ARVALID && m_AXI_ARREADY) s_rvalid <= 1'b1;
            else if (s_rvalid && m_AXI_RREADY) s_rvalid <= 1'b0;
        end
    end

    // Cumulative bus monitor; tests compare deltas.
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
    int          awv_cycles = 0, arv_cycles = 0, early_bready = 0, stab_err = 0;
    logic [7:0]  last_awaddr = 8'h0, last_araddr = 8'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;
    logic        p_rv = 1'b0, p_rr = 1'b0, p_rl = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
    logic [31:0] p_rd = 32'h0;
    logic [7:0]  p_awa = 8'h0;

    always @(posedge clk) begin
        if (rst) begin
            p_rv  <= 1'b0;
            p_awv <= 1'b0;
        end else begin
            if (m_AXI_AWVALID && m_AXI_AWREADY) begin
                aw_cnt <= aw_cnt + 1;
                last_awaddr <= m_AXI_AWADDR;
            end
            if (m_AXI_WVALID && m_AXI_WREADY) begin
                w_cnt <= w_cnt + 1;
                last_wdata <= m_AXI_WDATA;
                last_wstrb <= m_AXI_WSTRB;
            end
            if (m_AXI_ARVALID && m_AXI_ARREADY) begin
                ar_cnt <= ar_cnt + 1;
                last_araddr <= m_AXI_ARADDR;
            end
            if (m_AXI_BVALID && m_AXI_BREADY) b_cnt <= b_cnt + 1;
            if (m_AXI_AWVALID) awv_cycles <= awv_cycles + 1;
            if (m_AXI_ARVALID) arv_cycles <= arv_cycles + 1;
            if (m_AXI_BREADY && (m_AXI_AWVALID || m_AXI_WVALID)) early_bready <= early_bready + 1;
            if ((p_rv && !p_rr && (!rsp_TVALID || rsp_TDATA !== p_rd || rsp_TLAST !== p_rl)) ||
                (p_awv && !p_awr && (!m_AXI_AWVALID || m_AXI_AWADDR !== p_awa)))
                stab_err <= stab_err + 1;
            p_rv  <= rsp_TVALID;
            p_rr  <= rsp_TREADY;
            p_rd  <= rsp_TDATA;
            p_rl  <= rsp_TLAST;
            p_awv <= m_AXI_AWVALID;
            p_awr <= m_AXI_AWREADY;
            p_awa <= m_AXI_AWADDR;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int n;
        cmd_TDATA  = d;
        cmd_TLAST  = l;
        cmd_TVALID = 1'b1;
        n = 0;
        while (cmd_TREADY !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_TREADY=%b after %0d cycles, required 1", cmd_TREADY, n);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_TVALID = 1'b0;
        cmd_TLAST  = 1'b0;
    endtask

    task automatic get_rsp(input int stall, input string name);
        int n;
        logic [32:0] exp;
        n = 0;
        while (rsp_TVALID !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s rsp_timeout: rsp_TVALID=%b, required 1", name, rsp_TVALID);
            return;
        end
        repeat (stall) @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s rsp_unexpected: got last=%b data=%h, required none", name, rsp_TLAST, rsp_TDATA);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_TLAST, rsp_TDATA} !== exp)
                begin
                    errors++;
                    $display("FAIL %s rsp_beat: got last=%b data=%h, required last=%b data=%h",
                             name, rsp_TLAST, rsp_TDATA, exp[32], exp[31:0]);
                end
        end
        rsp_TREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_TREADY, m_AXI_AWVALID, m_AXI_WVALID, m_AXI_BREADY, m_AXI_ARVALID,
             m_AXI_RREADY, rsp_TVALID, rsp_TLAST} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {cmd_TREADY, m_AXI_AWVALID, m_AXI_WVALID, m_AXI_BREADY, m_AXI_ARVALID,
                      m_AXI_RREADY, rsp_TVALID, rsp_TLAST});
        end
        checks++;
        if ({m_AXI_AWADDR, m_AXI_ARADDR, m_AXI_WDATA, m_AXI_WSTRB, rsp_TDATA} !== 84'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0",
                     {m_AXI_AWADDR, m_AXI_ARADDR, m_AXI_WDATA, m_AXI_WSTRB, rsp_TDATA});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready: got %b, required 1", cmd_TREADY);
        end
    endtask

    task automatic test_write_basic();
        int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, eb0 = early_bready;
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h8000_0000});
        drive_beat(32'h8F00_0010, 1'b0);
        drive_beat(32'hDEAD_BEEF, 1'b1);
        get_rsp(0, "wr_basic");
        get_rsp(0, "wr_basic");
        checks++;
        if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL wr_basic_counts: got aw=%0d w=%0d b=%0d, required 1 1 1",
                     aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
        end
        checks++;
        if ({last_awaddr, last_wstrb, last_wdata} !== {8'h10, 4'hF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wr_basic_fields: got addr=%h strb=%h data=%h, required 10 f deadbeef",
                     last_awaddr, last_wstrb, last_wdata);
        end
        checks++;
        if (early_bready - eb0 !== 0) begin
            errors++;
            $display("FAIL wr_basic_bready: got %0d early cycles, required 0", early_bready - eb0);
        end
    endtask

    task automatic test_read_basic();
        int ar0 = ar_cnt;
        rdata_val = 32'h1234_5678;
        rresp_val = 2'b00;
        exp_q.push_back({1'b0, 32'h1234_5678});
        exp_q.push_back({1'b1, 32'h0});
        drive_beat(32'h0000_0024, 1'b1);
        checks++;
        if (m_AXI_ARVALID !== 1'b1) begin
            errors++;
            $display("FAIL rd_ar_latency: ARVALID=%b, required 1", m_AXI_ARVALID);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL rd_rsp_latency: rsp_TVALID=%b, required 1", rsp_TVALID);
        end
        get_rsp(0, "rd_basic");
        get_rsp(0, "rd_basic");
        checks++;
        if ({ar_cnt - ar0, 24'h0, last_araddr} !== {32'd1, 32'h24}) begin
            errors++;
            $display("FAIL rd_basic_ar: got count=%0d addr=%h, required 1 24", ar_cnt - ar0, last_araddr);
        end
    endtask

    task automatic test_write_delays();
        int cfg_aw[3] = '{3, 0, 0};
        int cfg_w[3]  = '{0, 3, 0};
        for (int i = 0; i < 3; i++) begin
            int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, eb0 = early_bready, st0 = stab_err;
            aw_delay = cfg_aw[i];
            w_delay  = cfg_w[i];
            exp_q.push_back({1'b0, 32'h0});
            exp_q.push_back({1'b1, 32'h8000_0000});
            drive_beat(32'h8300_0040, 1'b0);
            drive_beat(32'hA5A5_0000 + i, 1'b1);
            get_rsp(0, "wr_delay");
            get_rsp(0, "wr_delay");
            checks++;
            if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, early_bready - eb0, stab_err - st0} !==
                {32'd1, 32'd1, 32'd1, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL wr_delay%0d: got aw=%0d w=%0d b=%0d early=%0d unstable=%0d, required 1 1 1 0 0",
                         i, aw_cnt - aw0, w_cnt - w0, b_cnt - b0, early_bready - eb0, stab_err - st0);
            end
            checks++;
            if ({last_awaddr, last_wstrb, last_wdata} !== {8'h40, 4'h3, 32'hA5A5_0000 + i}) begin
                errors++;
                $display("FAIL wr_delay%0d_fields: got addr=%h strb=%h data=%h", i,
                         last_awaddr, last_wstrb, last_wdata);
            end
        end
        aw_delay = 0;
        w_delay  = 0;
    endtask

    task automatic test_read_stall();
        int st0 = stab_err;
        rdata_val = 32'hCAFE_F00D;
        rresp_val = 2'b10;
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        exp_q.push_back({1'b1, 32'h0000_0002});
        drive_beat(32'h0000_0008, 1'b1);
        get_rsp(5, "rd_stall");
        get_rsp(5, "rd_stall");
        checks++;
        if (stab_err - st0 !== 0) begin
            errors++;
            $display("FAIL rd_stall_stable: got %0d unstable cycles, required 0", stab_err - st0);
        end
        rresp_val = 2'b00;
    endtask

    task automatic test_malformed();
        int awv0 = awv_cycles, arv0 = arv_cycles, aw0 = aw_cnt;
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h8000_0008});
        drive_beat(32'h8F00_0004, 1'b1);
        get_rsp(0, "bad_wr");
        get_rsp(0, "bad_wr");
        checks++;
        if (awv_cycles - awv0 !== 0) begin
            errors++;
            $display("FAIL bad_wr_noaw: got %0d AWVALID cycles, required 0", awv_cycles - awv0);
        end
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h0000_0008});
        drive_beat(32'h0000_0030, 1'b0);
        drive_beat(32'h1111_1111, 1'b0);
        drive_beat(32'h2222_2222, 1'b1);
        get_rsp(0, "bad_rd");
        get_rsp(0, "bad_rd");
        checks++;
        if (arv_cycles - arv0 !== 0) begin
            errors++;
            $display("FAIL bad_rd_noar: got %0d ARVALID cycles, required 0", arv_cycles - arv0);
        end
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h8000_0008});
        drive_beat(32'h8F00_0014, 1'b0);
        drive_beat(32'h55AA_55AA, 1'b0);
        drive_beat(32'h0000_0099, 1'b1);
        get_rsp(0, "long_wr");
        get_rsp(0, "long_wr");
        checks++;
        if ({aw_cnt - aw0, last_awaddr, last_wdata} !== {32'd1, 8'h14, 32'h55AA_55AA}) begin
            errors++;
            $display("FAIL long_wr_performed: got aw=%0d addr=%h data=%h, required 1 14 55aa55aa",
                     aw_cnt - aw0, last_awaddr, last_wdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        aw_delay = 20;
        drive_beat(32'h8F00_0018, 1'b0);
        drive_beat(32'h0BAD_0BAD, 1'b1);
        n = 0;
        while (m_AXI_AWVALID !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_AXI_AWVALID !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: AWVALID=%b, required 1", m_AXI_AWVALID);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_AXI_AWVALID, m_AXI_WVALID, m_AXI_BREADY, cmd_TREADY, rsp_TVALID} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got %b, required 00000",
                     {m_AXI_AWVALID, m_AXI_WVALID, m_AXI_BREADY, cmd_TREADY, rsp_TVALID});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        aw_delay = 0;
        seen = 0;
        rsp_TREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_TVALID === 1'b1) seen++;
        end
        rsp_TREADY = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_norsp: got %0d response cycles, required 0", seen);
        end
        rdata_val = 32'h0BAD_F00D;
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        exp_q.push_back({1'b1, 32'h0});
        drive_beat(32'h0000_0044, 1'b1);
        get_rsp(0, "rst_mid_read");
        get_rsp(0, "rst_mid_read");
        checks++;
        if (last_araddr !== 8'h44) begin
            errors++;
            $display("FAIL rst_mid_araddr: got %h, required 44", last_araddr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_delays();
        test_read_stall();
        test_malformed();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d beats left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
